// File: rtl/pcie_egress_fifo_stager.sv
// ---------------------------------------------------------------------------
// pcie_egress_fifo_stager
//
// Two-bank ping-pong dword buffer sitting directly upstream of the PCIe
// egress engine. The user side fills one bank and commits it as one TLP
// payload. Meanwhile the egress engine drains the other bank through a
// rdy/act/size/data/stb FIFO handshake, so back-to-back MWr TLPs do not stall
// the host side.
//
// Build option:
//   PCIE_EGRESS_STAGER_AUTO_COMMIT_EN
//     When defined, a write that fills the bank to 2^ADDR_WIDTH dwords commits
//     the bank in the same cycle.
//     When undefined, a full fill bank stays open and further writes are
//     dropped with o_wr_overflow.
//
// Parameters:
//   ADDR_WIDTH      log2 of bank depth in dwords (7 -> 128 dwords = 512 B)
//
// Ports:
//   clk             clock, all logic on the rising edge
//   rst_n           asynchronous active-low reset
//   o_wr_rdy        fill bank is open and has room
//   i_wr_stb        write i_wr_data into the fill bank
//   i_wr_data[31:0] write dword
//   i_wr_commit     close the fill bank as one payload
//   o_wr_overflow   one-cycle pulse (registered) after a dropped write
//   o_fifo_rdy      a committed bank is waiting and not yet claimed
//   i_fifo_act      consumer claim level; rising edge claims, falling releases
//   o_fifo_size     dword count of the offered/claimed bank, zero-extended
//   o_fifo_data     current dword of the claimed bank (show-ahead)
//   i_fifo_stb      advance to the next dword
//   o_rd_underflow  one-cycle pulse (registered) after a strobe past the end
//   dbg_bank_state  {bank1_state, bank0_state}: 0 FREE, 1 FILL, 2 FULL, 3 DRAIN
//
// Handshake semantics:
//   Write side: a dword transfers on every cycle where i_wr_stb and o_wr_rdy
//   are both high; i_wr_stb with o_wr_rdy low drops the dword and flags
//   o_wr_overflow. Read side: o_fifo_rdy offers a bank; the consumer takes it
//   with a rising i_fifo_act, reads o_fifo_data and advances with i_fifo_stb
//   (one dword per strobe, any rate), and hands the bank back with a falling
//   i_fifo_act, whether or not every dword was read.
// ---------------------------------------------------------------------------
module pcie_egress_fifo_stager #(
    parameter int ADDR_WIDTH = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_wr_rdy,
    input  logic        i_wr_stb,
    input  logic [31:0] i_wr_data,
    input  logic        i_wr_commit,
    output logic        o_wr_overflow,
    output logic        o_fifo_rdy,
    input  logic        i_fifo_act,
    output logic [23:0] o_fifo_size,
    output logic [31:0] o_fifo_data,
    input  logic        i_fifo_stb,
    output logic        o_rd_underflow,
    output logic [3:0]  dbg_bank_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

`ifdef PCIE_EGRESS_STAGER_AUTO_COMMIT_EN
    localparam bit AUTO_COMMIT = 1'b1;
`else
    localparam bit AUTO_COMMIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        BANK_FREE  = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2,
        BANK_DRAIN = 2'd3
    } bank_state_t;

    bank_state_t   bank_st  [2];
    logic [CW-1:0] bank_cnt [2];

    logic          wr_bank;
    logic [CW-1:0] wr_cnt;

    // rd_next is the oldest committed bank (the 1-entry pending slot is
    // "bank_st[rd_next] == FULL"); rd_bank is the bank most recently claimed.
    // Commits and claims both alternate banks, so the two pointers keep
    // commit order without a separate queue.
    logic          rd_next;
    logic          rd_bank;
    logic [CW-1:0] rd_ptr;
    logic          act_q;

    logic [31:0]   mem [2*DEPTH];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic          fill_open;
    logic          wr_room;
    logic          wr_accept;
    logic [CW-1:0] wr_cnt_next;
    logic          auto_fire;
    logic          commit_fire;
    logic          act_rise;
    logic          act_fall;
    logic          pend_valid;
    logic          drain_active;
    logic          claim_fire;
    logic          release_fire;
    logic          rd_at_end;
    logic          stb_adv;
    logic          stb_under;
    logic [CW-1:0] rd_sel;

    always_comb begin
        fill_open    = (bank_st[wr_bank] == BANK_FREE) || (bank_st[wr_bank] == BANK_FILL);
        wr_room      = (wr_cnt != CNT_FULL);
        wr_accept    = i_wr_stb && fill_open && wr_room;
        wr_cnt_next  = wr_cnt + CW'(wr_accept);
        auto_fire    = AUTO_COMMIT && wr_accept && (wr_cnt_next == CNT_FULL);
        // Count includes a write landing in the same cycle; an empty bank
        // never commits.
        commit_fire  = (i_wr_commit || auto_fire) && fill_open && (wr_cnt_next != '0);

        act_rise     = i_fifo_act && !act_q;
        act_fall     = !i_fifo_act && act_q;
        pend_valid   = (bank_st[rd_next] == BANK_FULL);
        drain_active = (bank_st[rd_bank] == BANK_DRAIN);
        claim_fire   = act_rise && pend_valid;
        release_fire = act_fall && drain_active;

        rd_at_end    = (rd_ptr == bank_cnt[rd_bank]);
        stb_adv      = i_fifo_stb && drain_active && !rd_at_end;
        stb_under    = i_fifo_stb && drain_active && rd_at_end;

        // Once every dword has been strobed out, keep showing the last one
        // rather than stale RAM contents. A claimed bank always holds at
        // least one dword, so the subtraction cannot wrap.
        rd_sel       = rd_at_end ? (rd_ptr - CW'(1)) : rd_ptr;
    end

    // ------------------------------------------------------------------
    // Bank state machine and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0]     <= BANK_FREE;
            bank_st[1]     <= BANK_FREE;
            bank_cnt[0]    <= '0;
            bank_cnt[1]    <= '0;
            wr_bank        <= 1'b0;
            wr_cnt         <= '0;
            rd_next        <= 1'b0;
            rd_bank        <= 1'b0;
            rd_ptr         <= '0;
            act_q          <= 1'b0;
            o_wr_overflow  <= 1'b0;
            o_rd_underflow <= 1'b0;
        end else begin
            act_q          <= i_fifo_act;
            o_wr_overflow  <= i_wr_stb && !wr_accept;
            o_rd_underflow <= stb_under;

            // Fill side
            if (wr_accept && (bank_st[wr_bank] == BANK_FREE)) begin
                bank_st[wr_bank] <= BANK_FILL;
            end
            if (commit_fire) begin
                bank_st[wr_bank]  <= BANK_FULL;
                bank_cnt[wr_bank] <= wr_cnt_next;
                wr_bank           <= ~wr_bank;
                wr_cnt            <= '0;
            end else begin
                wr_cnt <= wr_cnt_next;
            end

            // Drain side. The claimed bank is never the fill bank, so these
            // updates never collide with the fill-side ones above.
            if (claim_fire) begin
                bank_st[rd_next] <= BANK_DRAIN;
                rd_bank          <= rd_next;
                rd_next          <= ~rd_next;
                rd_ptr           <= '0;
            end else if (stb_adv) begin
                rd_ptr <= rd_ptr + CW'(1);
            end

            if (release_fire) begin
                bank_st[rd_bank] <= BANK_FREE;
            end
        end
    end

    // Bank storage: plain RAM, no reset. Data left behind by a reset is
    // unreachable because every bank returns to FREE with a zero count.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[{wr_bank, wr_cnt[ADDR_WIDTH-1:0]}] <= i_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_wr_rdy       = fill_open && wr_room;
        o_fifo_rdy     = pend_valid && !i_fifo_act;
        o_fifo_size    = 24'd0;
        o_fifo_data    = 32'd0;
        dbg_bank_state = {bank_st[1], bank_st[0]};

        if (drain_active) begin
            o_fifo_size = 24'(bank_cnt[rd_bank]);
        end else if (pend_valid) begin
            o_fifo_size = 24'(bank_cnt[rd_next]);
        end

        // rd_sel never exceeds DEPTH-1; its top bit only guards the index.
        if (drain_active && !rd_sel[ADDR_WIDTH]) begin
            o_fifo_data = mem[{rd_bank, rd_sel[ADDR_WIDTH-1:0]}];
        end
    end

endmodule

// File: tb/tb_pcie_egress_fifo_stager.sv
// ---------------------------------------------------------------------------
// Directed testbench for pcie_egress_fifo_stager.
// Inputs are driven 1 ns after the rising edge; outputs are sampled at the
// same point, after the edge has taken effect.
// ---------------------------------------------------------------------------
module tb_pcie_egress_fifo_stager;

    localparam int AW    = 7;
    localparam int DEPTH = 1 << AW;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        o_wr_rdy;
    logic        i_wr_stb;
    logic [31:0] i_wr_data;
    logic        i_wr_commit;
    logic        o_wr_overflow;
    logic        o_fifo_rdy;
    logic        i_fifo_act;
    logic [23:0] o_fifo_size;
    logic [31:0] o_fifo_data;
    logic        i_fifo_stb;
    logic        o_rd_underflow;
    logic [3:0]  dbg_bank_state;

    pcie_egress_fifo_stager #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .o_wr_rdy       (o_wr_rdy),
        .i_wr_stb       (i_wr_stb),
        .i_wr_data      (i_wr_data),
        .i_wr_commit    (i_wr_commit),
        .o_wr_overflow  (o_wr_overflow),
        .o_fifo_rdy     (o_fifo_rdy),
        .i_fifo_act     (i_fifo_act),
        .o_fifo_size    (o_fifo_size),
        .o_fifo_data    (o_fifo_data),
        .i_fifo_stb     (i_fifo_stb),
        .o_rd_underflow (o_rd_underflow),
        .dbg_bank_state (dbg_bank_state)
    );

    // scoreboard
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        i_wr_stb  = 1'b1;
        i_wr_data = d;
        tick();
        i_wr_stb  = 1'b0;
    endtask

    task automatic wr_push(input logic [31:0] d);
        exp_q.push_back(d);
        wr(d);
    endtask

    task automatic commit();
        i_wr_commit = 1'b1;
        tick();
        i_wr_commit = 1'b0;
    endtask

    task automatic claim();
        i_fifo_act = 1'b1;
        tick();
    endtask

    task automatic release_bank();
        i_fifo_act = 1'b0;
        tick();
    endtask

    task automatic strobe();
        i_fifo_stb = 1'b1;
        tick();
        i_fifo_stb = 1'b0;
    endtask

    // Checks n dwords against the expected queue, strobing between them.
    task automatic drain_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_eq(tag, o_fifo_data, exp_q.pop_front());
            if (i < n - 1) strobe();
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        i_wr_stb    = 1'b0;
        i_wr_data   = 32'd0;
        i_wr_commit = 1'b0;
        i_fifo_act  = 1'b0;
        i_fifo_stb  = 1'b0;
        repeat (3) tick();

        // reset values
        check_eq("rst_wr_rdy",   32'(o_wr_rdy),       32'd1);
        check_eq("rst_fifo_rdy", 32'(o_fifo_rdy),     32'd0);
        check_eq("rst_size",     32'(o_fifo_size),    32'd0);
        check_eq("rst_data",     o_fifo_data,         32'd0);
        check_eq("rst_ovf",      32'(o_wr_overflow),  32'd0);
        check_eq("rst_und",      32'(o_rd_underflow), 32'd0);
        check_eq("rst_banks",    32'(dbg_bank_state), 32'h0);
        rst_n = 1'b1;
        tick();

        // single payload (bank 0)
        for (int i = 1; i <= 5; i++) wr_push(32'(i));
        check_eq("sp_fill_state", 32'(dbg_bank_state), 32'h1);
        commit();
        check_eq("sp_rdy",     32'(o_fifo_rdy),  32'd1);
        check_eq("sp_size",    32'(o_fifo_size), 32'd5);
        check_eq("sp_wr_rdy",  32'(o_wr_rdy),    32'd1);
        claim();
        check_eq("sp_rdy_claimed", 32'(o_fifo_rdy), 32'd0);
        drain_check("sp_data", 5);
        strobe();
        check_eq("sp_5th_und",  32'(o_rd_underflow), 32'd0);
        check_eq("sp_5th_data", o_fifo_data, 32'd5);
        strobe();
        check_eq("sp_6th_und",  32'(o_rd_underflow), 32'd1);
        check_eq("sp_6th_data", o_fifo_data, 32'd5);
        tick();
        check_eq("sp_und_pulse", 32'(o_rd_underflow), 32'd0);
        release_bank();
        check_eq("sp_rel_banks", 32'(dbg_bank_state), 32'h0);
        check_eq("sp_rel_rdy",   32'(o_fifo_rdy), 32'd0);
        check_eq("sp_rel_size",  32'(o_fifo_size), 32'd0);

        // ping-pong: A = bank 1 (4 dwords), B = bank 0 (3 dwords)
        for (int i = 0; i < 4; i++) wr_push(32'h10 + 32'(i));
        commit();
        claim();
        for (int i = 0; i < 3; i++) wr(32'h20 + 32'(i));
        commit();
        check_eq("pp_rdy_busy",  32'(o_fifo_rdy), 32'd0);
        check_eq("pp_size_a",    32'(o_fifo_size), 32'd4);
        check_eq("pp_wr_rdy",    32'(o_wr_rdy), 32'd0);
        check_eq("pp_banks",     32'(dbg_bank_state), 32'hE);
        drain_check("pp_data_a", 2);
        exp_q.delete();
        release_bank();
        check_eq("pp_b_rdy",  32'(o_fifo_rdy), 32'd1);
        check_eq("pp_b_size", 32'(o_fifo_size), 32'd3);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h20 + 32'(i));
        claim();
        drain_check("pp_data_b", 3);
        release_bank();

        // both full: bank 1 (2 dwords) then bank 0 (1 dword)
        wr_push(32'h30);
        wr_push(32'h31);
        commit();
        wr(32'h40);
        commit();
        check_eq("bf_wr_rdy", 32'(o_wr_rdy), 32'd0);
        check_eq("bf_rdy",    32'(o_fifo_rdy), 32'd1);
        check_eq("bf_size",   32'(o_fifo_size), 32'd2);
        check_eq("bf_banks",  32'(dbg_bank_state), 32'hA);
        wr(32'h99);
        check_eq("bf_ovf",    32'(o_wr_overflow), 32'd1);
        check_eq("bf_size_kept", 32'(o_fifo_size), 32'd2);
        commit();
        check_eq("bf_ovf_pulse", 32'(o_wr_overflow), 32'd0);
        check_eq("bf_banks_kept", 32'(dbg_bank_state), 32'hA);
        claim();
        drain_check("bf_data_1", 2);
        release_bank();
        check_eq("bf_next_rdy",  32'(o_fifo_rdy), 32'd1);
        check_eq("bf_next_size", 32'(o_fifo_size), 32'd1);
        check_eq("bf_wr_rdy_back", 32'(o_wr_rdy), 32'd1);
        claim();
        check_eq("bf_data_0", o_fifo_data, 32'h40);
        release_bank();

        // zero-count commit, then write+commit in one cycle (bank 1)
        commit();
        check_eq("zc_rdy",   32'(o_fifo_rdy), 32'd0);
        check_eq("zc_banks", 32'(dbg_bank_state), 32'h0);
        wr_push(32'h50);
        exp_q.push_back(32'h51);
        i_wr_commit = 1'b1;
        wr(32'h51);
        i_wr_commit = 1'b0;
        check_eq("wc_rdy",  32'(o_fifo_rdy), 32'd1);
        check_eq("wc_size", 32'(o_fifo_size), 32'd2);
        claim();
        drain_check("wc_data", 2);
        release_bank();

        // full bank: 128 writes into bank 0
        for (int i = 0; i < DEPTH; i++) wr_push(32'h100 + 32'(i));
`ifdef PCIE_EGRESS_STAGER_AUTO_COMMIT_EN
        check_eq("fb_auto_rdy",  32'(o_fifo_rdy), 32'd1);
        check_eq("fb_auto_size", 32'(o_fifo_size), 32'd128);
        commit();
        check_eq("fb_auto_zc",   32'(dbg_bank_state), 32'h2);
`else
        check_eq("fb_rdy_open",  32'(o_fifo_rdy), 32'd0);
        check_eq("fb_wr_rdy",    32'(o_wr_rdy), 32'd0);
        wr(32'hDEAD);
        check_eq("fb_ovf",       32'(o_wr_overflow), 32'd1);
        check_eq("fb_rdy_still", 32'(o_fifo_rdy), 32'd0);
        commit();
        check_eq("fb_rdy",       32'(o_fifo_rdy), 32'd1);
        check_eq("fb_size",      32'(o_fifo_size), 32'd128);
`endif
        claim();
        drain_check("fb_data", DEPTH);
        strobe();
        strobe();
        check_eq("fb_und",      32'(o_rd_underflow), 32'd1);
        check_eq("fb_last",     o_fifo_data, 32'h17F);
        release_bank();

        // reset mid-drain (bank 1)
        wr(32'h60);
        wr(32'h61);
        wr(32'h62);
        commit();
        claim();
        strobe();
        strobe();
        check_eq("rm_pre_data", o_fifo_data, 32'h62);
        rst_n = 1'b0;
        #1;
        check_eq("rm_wr_rdy",  32'(o_wr_rdy), 32'd1);
        check_eq("rm_rdy",     32'(o_fifo_rdy), 32'd0);
        check_eq("rm_size",    32'(o_fifo_size), 32'd0);
        check_eq("rm_data",    o_fifo_data, 32'd0);
        check_eq("rm_banks",   32'(dbg_bank_state), 32'h0);
        i_fifo_act = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        wr_push(32'h70);
        wr_push(32'h71);
        commit();
        check_eq("rm_new_rdy",  32'(o_fifo_rdy), 32'd1);
        check_eq("rm_new_size", 32'(o_fifo_size), 32'd2);
        claim();
        drain_check("rm_new_data", 2);
        release_bank();
        check_eq("rm_end_banks", 32'(dbg_bank_state), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pcie_egress_fifo_stager.md
# pcie_egress_fifo_stager

Two-bank ping-pong dword buffer directly upstream of the PCIe egress engine. The user/Wishbone side writes dwords into a fill bank and commits them as one TLP payload. The egress engine sees them through the rdy/act/size/data/stb FIFO handshake. One bank fills while the other drains, so back-to-back MWr TLPs need no host-side stall.

## Interface
Parameters:
- `ADDR_WIDTH`, default 7: log2 of bank depth in dwords (128 dwords, which is 512 B, the max payload).

Ports:
- `clk`  in  1: single clock; all logic rises on this edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `o_wr_rdy`  out  1: the current fill bank is empty or partly filled and may take writes.
- `i_wr_stb`  in  1: write `i_wr_data` into the fill bank.
- `i_wr_data`  in  32: write dword.
- `i_wr_commit`  in  1: close the fill bank as one payload.
- `o_wr_overflow`  out  1: one-cycle pulse when a write is dropped.
- `o_fifo_rdy`  out  1: a committed bank is waiting and not yet claimed.
- `i_fifo_act`  in  1: the consumer claims the bank (level); a falling edge releases it.
- `o_fifo_size`  out  24: dword count of the offered/claimed bank, zero-extended.
- `o_fifo_data`  out  32: the current dword (show-ahead).
- `i_fifo_stb`  in  1: advance to the next dword.
- `o_rd_underflow`  out  1: one-cycle pulse on a strobe past `o_fifo_size`.

## Operation
- Bank state is one of FREE, FILL, FULL (committed) or DRAIN. There is one write pointer `wr_bank`. Commit order is kept in a 1-entry pending flag plus a bank index.
- **Write:**
  - `i_wr_stb` with `o_wr_rdy` stores the dword at `wr_cnt` and increments `wr_cnt` (ADDR_WIDTH+1 bits).
  - Writing to a FREE bank moves it to FILL.
  - A write while `wr_cnt == 2^ADDR_WIDTH`, or while no bank is FREE or FILL, is dropped and pulses `o_wr_overflow`.
- **Commit:**
  - `i_wr_commit` with `wr_cnt != 0` moves FILL to FULL, latches the count and moves `wr_bank` to the other bank.
  - A commit with `wr_cnt == 0` is ignored.
  - A write and a commit in the same cycle: the write is included in the committed count.
- **Offer:** `o_fifo_rdy = (oldest bank FULL) && !i_fifo_act`. `o_fifo_size` shows that bank's count whenever `o_fifo_rdy` is high.
- **Claim:**
  - A rising `i_fifo_act` moves the oldest FULL bank to DRAIN and clears `rd_ptr`.
  - `o_fifo_data = mem[rd_bank][rd_ptr]`, read combinationally from distributed RAM.
- **Drain:**
  - `i_fifo_stb` increments `rd_ptr`.
  - A strobe when `rd_ptr == size` leaves `rd_ptr` unchanged and pulses `o_rd_underflow`.
- **Release:** a falling `i_fifo_act` moves DRAIN to FREE whether or not all data was read, and the next FULL bank is offered.
- Both banks FULL: `o_wr_rdy = 0` until a release.
- `i_fifo_act` high with no FULL bank: no claim is made and data is undefined. The consumer is forbidden from doing this.

## Timing
- Reset values:
  - Both banks FREE.
  - `o_wr_rdy = 1`, `o_fifo_rdy = 0`, `o_fifo_size = 0`, `o_fifo_data = 0`.
  - `o_wr_overflow = 0`, `o_rd_underflow = 0`.
  - All pointers 0.
- Commit in cycle N: `o_fifo_rdy` is high in N+1 if no bank is in DRAIN.
- `i_fifo_act` rising in N: `o_fifo_rdy` falls in N+1. `o_fifo_data` holds dword 0 from N+1.
- `i_fifo_stb` in N: the next dword appears in N+1. Strobes may arrive on every cycle.
- `i_fifo_act` falling in N: the bank is FREE in N+1. `o_wr_rdy`/`o_fifo_rdy` update in N+1.
- A write and a drain on different banks in the same cycle are independent.
- `rst_n` asserted mid-transfer: immediate return to reset values. Buffered data is discarded.

## Configuration
- `PCIE_EGRESS_STAGER_AUTO_COMMIT_EN`
  - Defined: a write that makes `wr_cnt` reach `2^ADDR_WIDTH` auto-commits the bank in that cycle. A later `i_wr_commit` with zero count is ignored.
  - Undefined: a full fill bank stays in FILL, and further writes are dropped with `o_wr_overflow`.

## Test plan
- **Single payload:** write 5 dwords 0x1..0x5, then commit. Expect `o_fifo_rdy = 1` and `o_fifo_size = 5`. Claim and strobe 5 times: data reads 0x1..0x5. Release: bank FREE.
- **Ping-pong:** commit A (4 dwords), claim A, write and commit B (3 dwords) while A drains. Release A: B is offered next cycle with size 3 and data intact.
- **Both full:** commit two banks. Expect `o_wr_rdy = 0`. The next write pulses `o_wr_overflow` and both sizes are unchanged.
- **Boundaries:**
  - A commit with zero writes gives no `o_fifo_rdy`.
  - A write and commit in the same cycle gives size including that write.
  - A 6th strobe on a size-5 bank pulses `o_rd_underflow` and data holds dword 4.
- **Full bank:** 128 writes.
  - Macro defined: auto-commit, with `o_fifo_size = 128` next cycle.
  - Macro undefined: the 129th write pulses `o_wr_overflow` and nothing is offered until commit.
- **Reset mid-drain:** assert `rst_n = 0` after 2 strobes. Expect all outputs at reset values at once, and a new write/commit flow works after deassertion.
